// File: rtl/ex_mem_lsu_pkg.sv
// Shared types and encodings for the memory-stage load/store unit.
package ex_mem_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

endpackage

// File: rtl/ex_mem_lsu_load_align.sv
// Load data extraction: lane shift by byte offset, size select from the access mask,
// then sign or zero extension.
module lsu_load_align
  import ex_mem_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [7:0]      mask_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    case (mask_i)
      MASK_B:  data_o = {{(XLEN-8){signed_i & shifted[7]}},   shifted[7:0]};
      MASK_H:  data_o = {{(XLEN-16){signed_i & shifted[15]}}, shifted[15:0]};
      MASK_W:  data_o = {{(XLEN-32){signed_i & shifted[31]}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/ex_mem_lsu.sv
// Memory-stage load/store unit: accepts EX results, runs one data-memory transaction
// at a time and presents a registered writeback result.
module ex_mem_lsu
  import ex_mem_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic              ex_is_write_dmem,
  input  logic [1:0]        ex_wb_select,
  input  logic [7:0]        ex_write_width,
  input  logic              ex_load_signed,
  input  logic [XLEN-1:0]   ex_dmem_write_data,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [XLEN-1:0]   dmem_req_addr,
  output logic [XLEN-1:0]   dmem_req_wdata,
  output logic [STRB_W-1:0] dmem_req_strb,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rsp_rdata,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data
);

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0]   addr_q,  addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0] strb_q,  strb_d;
  logic              we_q,    we_d;
  logic [7:0]        mask_q,  mask_d;
  logic              sgn_q,   sgn_d;
  logic              wbv_q,   wbv_d;
  logic [XLEN-1:0]   wbd_q,   wbd_d;

  logic            mem_op;
  logic [2:0]      ex_off;
  logic [XLEN-1:0] load_data;

  // A store wins over a load request when both are flagged.
  assign mem_op = ex_is_write_dmem || (ex_wb_select == WB_LOAD);
  assign ex_off = ex_alu_result[2:0];

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dmem_rsp_rdata),
    .off_i    (addr_q[2:0]),
    .mask_i   (mask_q),
    .signed_i (sgn_q),
    .data_o   (load_data)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ex_valid && mem_op) state_d = ST_REQ;
      ST_REQ:  if (dmem_req_ready)     state_d = we_q ? ST_IDLE : ST_RESP;
      ST_RESP: if (dmem_rsp_valid)     state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ex_ready       = (state_q == ST_IDLE);
    dmem_req_valid = (state_q == ST_REQ);
  end

  // Stores are lane-aligned at accept time so the request port is driven straight from flops.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    we_d    = we_q;
    mask_d  = mask_q;
    sgn_d   = sgn_q;
    wbv_d   = 1'b0;
    wbd_d   = wbd_q;
    if (state_q == ST_IDLE && ex_valid) begin
      if (mem_op) begin
        addr_d  = ex_alu_result;
        wdata_d = ex_dmem_write_data << {ex_off, 3'b000};
        strb_d  = ex_write_width[STRB_W-1:0] << ex_off;
        we_d    = ex_is_write_dmem;
        mask_d  = ex_write_width;
        sgn_d   = ex_load_signed;
      end else if (ex_wb_select == WB_ALU) begin
        wbv_d = 1'b1;
        wbd_d = ex_alu_result;
      end
    end
    if (state_q == ST_RESP && dmem_rsp_valid) begin
      wbv_d = 1'b1;
      wbd_d = load_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      sgn_q   <= 1'b0;
      wbv_q   <= 1'b0;
      wbd_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      sgn_q   <= sgn_d;
      wbv_q   <= wbv_d;
      wbd_q   <= wbd_d;
    end
  end

  assign dmem_req_we    = we_q;
  assign dmem_req_addr  = addr_q;
  assign dmem_req_wdata = wdata_q;
  assign dmem_req_strb  = strb_q;
  assign wb_valid       = wbv_q;
  assign wb_data        = wbd_q;

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed and randomized bench for ex_mem_lsu with a byte-lane reference model.
module tb_ex_mem_lsu;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_alu_result;
  logic        ex_is_write_dmem;
  logic [1:0]  ex_wb_select;
  logic [7:0]  ex_write_width;
  logic        ex_load_signed;
  logic [63:0] ex_dmem_write_data;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [63:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_strb;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic        wb_valid;
  logic [63:0] wb_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_wb = '0;
  logic [7:0]  masks [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

  ex_mem_lsu #(.XLEN(64), .STRB_W(8)) dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .ex_valid           (ex_valid),
    .ex_ready           (ex_ready),
    .ex_alu_result      (ex_alu_result),
    .ex_is_write_dmem   (ex_is_write_dmem),
    .ex_wb_select       (ex_wb_select),
    .ex_write_width     (ex_write_width),
    .ex_load_signed     (ex_load_signed),
    .ex_dmem_write_data (ex_dmem_write_data),
    .dmem_req_valid     (dmem_req_valid),
    .dmem_req_ready     (dmem_req_ready),
    .dmem_req_we        (dmem_req_we),
    .dmem_req_addr      (dmem_req_addr),
    .dmem_req_wdata     (dmem_req_wdata),
    .dmem_req_strb      (dmem_req_strb),
    .dmem_rsp_valid     (dmem_rsp_valid),
    .dmem_rsp_rdata     (dmem_rsp_rdata),
    .wb_valid           (wb_valid),
    .wb_data            (wb_data)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: byte lanes moved one at a time.
  function automatic logic [7:0] m_strb(input logic [7:0] mask, input int off);
    logic [7:0] r = '0;
    for (int j = 0; j < 8; j++)
      if (j >= off && mask[j-off]) r[j] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] d, input int off);
    logic [63:0] r = '0;
    for (int j = 0; j < 8; j++)
      if (j >= off) r[8*j +: 8] = d[8*(j-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rd, input int off,
                                         input logic [7:0] mask, input logic sgn);
    logic [63:0] r = '0;
    int n;
    n = (mask == 8'h01) ? 1 : (mask == 8'h03) ? 2 : (mask == 8'h0F) ? 4 : 8;
    for (int i = 0; i < n; i++)
      if (off + i < 8) r[8*i +: 8] = rd[8*(off+i) +: 8];
    if (sgn && r[8*n-1])
      for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic idle_inputs();
    ex_valid           = 1'b0;
    ex_is_write_dmem   = 1'b0;
    ex_wb_select       = 2'b10;
    ex_write_width     = 8'h00;
    ex_load_signed     = 1'b0;
    ex_alu_result      = $urandom();
    ex_dmem_write_data = {$urandom(), $urandom()};
    dmem_req_ready     = 1'b0;
    dmem_rsp_valid     = 1'b0;
    dmem_rsp_rdata     = {$urandom(), $urandom()};
  endtask

  task automatic do_alu(input logic [63:0] v);
    ex_valid = 1'b1; ex_is_write_dmem = 1'b0; ex_wb_select = 2'b00; ex_alu_result = v;
    @(negedge sys_clk);
    exp_wb = v;
    chk("alu_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("alu_wb_data", wb_data, exp_wb);
    chk("alu_ex_ready", {63'd0, ex_ready}, 64'd1);
  endtask

  task automatic do_nowb(input logic [1:0] sel);
    ex_valid = 1'b1; ex_is_write_dmem = 1'b0; ex_wb_select = sel; ex_alu_result = {$urandom(), $urandom()};
    @(negedge sys_clk);
    idle_inputs();
    chk("nowb_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("nowb_wb_data", wb_data, exp_wb);
    chk("nowb_ex_ready", {63'd0, ex_ready}, 64'd1);
  endtask

  task automatic do_store(input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data,
                          input logic [1:0] sel, input int hold, input logic noise,
                          input logic [7:0] es, input logic [63:0] ew);
    ex_valid = 1'b1; ex_is_write_dmem = 1'b1; ex_wb_select = sel;
    ex_alu_result = addr; ex_write_width = mask; ex_dmem_write_data = data;
    dmem_req_ready = noise; dmem_rsp_valid = noise;
    @(negedge sys_clk);
    idle_inputs();
    chk("st_req_valid", {63'd0, dmem_req_valid}, 64'd1);
    chk("st_we", {63'd0, dmem_req_we}, 64'd1);
    chk("st_addr", dmem_req_addr, addr);
    chk("st_strb", {56'd0, dmem_req_strb}, {56'd0, es});
    chk("st_wdata", dmem_req_wdata, ew);
    chk("st_ex_ready", {63'd0, ex_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge sys_clk);
      chk("st_hold_valid", {63'd0, dmem_req_valid}, 64'd1);
      chk("st_hold_strb", {56'd0, dmem_req_strb}, {56'd0, es});
      chk("st_hold_wdata", dmem_req_wdata, ew);
      chk("st_hold_addr", dmem_req_addr, addr);
      chk("st_hold_ex_ready", {63'd0, ex_ready}, 64'd0);
    end
    dmem_req_ready = 1'b1;
    @(negedge sys_clk);
    dmem_req_ready = 1'b0;
    chk("st_done_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("st_done_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    chk("st_no_wb", {63'd0, wb_valid}, 64'd0);
    chk("st_wb_hold", wb_data, exp_wb);
  endtask

  task automatic do_load(input logic [63:0] addr, input logic [7:0] mask, input logic sgn,
                         input logic [63:0] rdata, input int lat, input logic spurious,
                         input logic [63:0] ev);
    ex_valid = 1'b1; ex_is_write_dmem = 1'b0; ex_wb_select = 2'b01;
    ex_alu_result = addr; ex_write_width = mask; ex_load_signed = sgn;
    @(negedge sys_clk);
    idle_inputs();
    chk("ld_req_valid", {63'd0, dmem_req_valid}, 64'd1);
    chk("ld_we", {63'd0, dmem_req_we}, 64'd0);
    chk("ld_addr", dmem_req_addr, addr);
    chk("ld_ex_ready", {63'd0, ex_ready}, 64'd0);
    if (spurious) begin
      dmem_rsp_valid = 1'b1;
      @(negedge sys_clk);
      dmem_rsp_valid = 1'b0;
      chk("ld_spur_req_valid", {63'd0, dmem_req_valid}, 64'd1);
      chk("ld_spur_no_wb", {63'd0, wb_valid}, 64'd0);
    end
    dmem_req_ready = 1'b1;
    @(negedge sys_clk);
    dmem_req_ready = 1'b0;
    chk("ld_resp_ex_ready", {63'd0, ex_ready}, 64'd0);
    chk("ld_resp_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    for (int i = 1; i < lat; i++) begin
      @(negedge sys_clk);
      chk("ld_wait_no_wb", {63'd0, wb_valid}, 64'd0);
      chk("ld_wait_ex_ready", {63'd0, ex_ready}, 64'd0);
    end
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
    @(negedge sys_clk);
    idle_inputs();
    exp_wb = ev;
    chk("ld_wb_valid", {63'd0, wb_valid}, 64'd1);
    chk("ld_wb_data", wb_data, exp_wb);
    chk("ld_done_ex_ready", {63'd0, ex_ready}, 64'd1);
    @(negedge sys_clk);
    chk("ld_pulse_one", {63'd0, wb_valid}, 64'd0);
    chk("ld_wb_hold", wb_data, exp_wb);
  endtask

  initial begin
    logic [63:0] a, d, rd;
    logic [7:0]  m;
    logic        s;
    int          kind;

    sys_rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge sys_clk);
    chk("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    chk("rst_we", {63'd0, dmem_req_we}, 64'd0);
    chk("rst_addr", dmem_req_addr, 64'd0);
    chk("rst_wdata", dmem_req_wdata, 64'd0);
    chk("rst_strb", {56'd0, dmem_req_strb}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);

    for (int i = 1; i <= 4; i++) do_alu(64'(i));
    idle_inputs();
    @(negedge sys_clk);
    chk("alu_stream_end", {63'd0, wb_valid}, 64'd0);
    chk("alu_stream_hold", wb_data, 64'd4);

    do_store(64'h1005, 8'h01, 64'hAB, 2'b10, 3, 1'b0, 8'h20, 64'h0000AB0000000000);
    do_load(64'h2002, 8'h03, 1'b1, 64'h0000000080010000, 1, 1'b0, 64'hFFFFFFFFFFFF8001);
    do_load(64'h2002, 8'h03, 1'b0, 64'h0000000080010000, 1, 1'b0, 64'h0000000000008001);
    do_load(64'h3004, 8'h0F, 1'b1, 64'h123456789ABCDEF0, 5, 1'b1, 64'h0000000012345678);
    do_store(64'h4006, 8'h0F, 64'hDDCCBBAA, 2'b01, 0, 1'b1, 8'hC0, 64'hBBAA000000000000);
    do_nowb(2'b11);

    // Reset while a load waits for its response.
    ex_valid = 1'b1; ex_wb_select = 2'b01; ex_alu_result = 64'h5000; ex_write_width = 8'hFF;
    @(negedge sys_clk);
    idle_inputs();
    dmem_req_ready = 1'b1;
    @(negedge sys_clk);
    dmem_req_ready = 1'b0;
    chk("rstmid_in_resp", {63'd0, ex_ready}, 64'd0);
    #2 sys_rst = 1'b0;
    #1;
    chk("rstmid_ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rstmid_req_valid", {63'd0, dmem_req_valid}, 64'd0);
    chk("rstmid_addr", dmem_req_addr, 64'd0);
    chk("rstmid_strb", {56'd0, dmem_req_strb}, 64'd0);
    chk("rstmid_wb_data", wb_data, 64'd0);
    chk("rstmid_wb_valid", {63'd0, wb_valid}, 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    exp_wb = '0;
    dmem_rsp_valid = 1'b1;
    @(negedge sys_clk);
    dmem_rsp_valid = 1'b0;
    chk("rstmid_late_rsp_wb", {63'd0, wb_valid}, 64'd0);
    chk("rstmid_late_rsp_data", wb_data, 64'd0);
    chk("rstmid_late_ready", {63'd0, ex_ready}, 64'd1);

    for (int it = 0; it < 80; it++) begin
      kind = int'($urandom_range(0, 3));
      a  = {$urandom(), $urandom()};
      d  = {$urandom(), $urandom()};
      rd = {$urandom(), $urandom()};
      m  = ($urandom_range(0, 4) == 4) ? 8'($urandom()) : masks[$urandom_range(0, 3)];
      s  = 1'($urandom());
      case (kind)
        0: begin do_alu(a); idle_inputs(); end
        1: do_nowb(2'($urandom_range(2, 3)));
        2: do_store(a, m, d, 2'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    1'($urandom()), m_strb(m, int'(a[2:0])), m_wdata(d, int'(a[2:0])));
        default: do_load(a, m, s, rd, int'($urandom_range(1, 4)), 1'($urandom()),
                         m_load(rd, int'(a[2:0]), m, s));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
